// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU pass-through plus a 32-cycle restoring divider FSM.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |divisor| > |dividend|.
module ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid_i,
   input  logic        mem_allowin_i,
   input  logic        excep_flush_i,
   input  logic        is_div_i,
   input  logic        div_signed_i,
   input  logic        div_rem_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic [31:0] alu_result_i,
   output logic        ex_allowin_o,
   output logic        ex_to_mem_valid_o,
   output logic [31:0] ex_result_o,
   output logic        div_busy_o
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_nxt;
   logic [5:0]          cnt;
   logic [DATA_W-1:0]   rem_r, quo_r, dvs_r, res_r;
   logic                neg_q_r, neg_r_r;

   logic [DATA_W-1:0]   a_abs, b_abs, rem_nxt, quo_nxt;
   logic [DATA_W:0]     shift;
   logic                ge, neg_q, neg_r, div_start, early, last_step, ex_ready_go;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
      cond_neg = neg ? (~v + 1'b1) : v;
   endfunction

   // Operand magnitudes and result-sign flags, valid when the divide is launched
   always_comb begin
      a_abs = cond_neg(src1_i, div_signed_i & src1_i[DATA_W-1]);
      b_abs = cond_neg(src2_i, div_signed_i & src2_i[DATA_W-1]);
      // A zero divisor must yield all-ones, so never sign-correct that quotient
      neg_q = div_signed_i & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]) & (src2_i != '0);
      neg_r = div_signed_i & src1_i[DATA_W-1];
`ifdef DIV_EARLY_OUT_EN
      early = (b_abs > a_abs);
`else
      early = 1'b0;
`endif
   end

   // One restoring radix-2 step: {rem, quo} shifts left, dividend bits leave quo as quotient bits enter
   always_comb begin
      shift   = {rem_r, quo_r[DATA_W-1]};
      ge      = (shift >= {1'b0, dvs_r});
      rem_nxt = ge ? (shift[DATA_W-1:0] - dvs_r) : shift[DATA_W-1:0];
      quo_nxt = {quo_r[DATA_W-2:0], ge};
   end

   assign ex_ready_go = !is_div_i || (state == DONE);
   assign div_start   = (state == IDLE) && ex_valid_i && is_div_i && !excep_flush_i;
   assign last_step   = (state == BUSY) && (cnt == 6'd31);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_start) state_nxt = early ? DONE : BUSY;
         BUSY:    if (cnt == 6'd31) state_nxt = DONE;
         DONE:    if (mem_allowin_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (excep_flush_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         dvs_r   <= '0;
         res_r   <= '0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else if (div_start) begin
         cnt     <= '0;
         rem_r   <= '0;
         quo_r   <= a_abs;
         dvs_r   <= b_abs;
         neg_q_r <= neg_q;
         neg_r_r <= neg_r;
         if (early) res_r <= div_rem_i ? cond_neg(a_abs, neg_r) : '0;
      end else if (state == BUSY) begin
         cnt   <= cnt + 6'd1;
         rem_r <= rem_nxt;
         quo_r <= quo_nxt;
         if (last_step)
            res_r <= div_rem_i ? cond_neg(rem_nxt, neg_r_r) : cond_neg(quo_nxt, neg_q_r);
      end
   end

   assign ex_allowin_o      = !ex_valid_i || (ex_ready_go && mem_allowin_i);
   assign ex_to_mem_valid_o = ex_valid_i && ex_ready_go && !excep_flush_i;
   assign ex_result_o       = is_div_i ? res_r : alu_result_i;
   assign div_busy_o        = (state != IDLE);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, hand-written corner sequences, random divides vs model.
module tb_ex_stage;

   logic        clk, rst_n;
   logic        ex_valid_i, mem_allowin_i, excep_flush_i, is_div_i, div_signed_i, div_rem_i;
   logic [31:0] src1_i, src2_i, alu_result_i;
   logic        ex_allowin_o, ex_to_mem_valid_o, div_busy_o;
   logic [31:0] ex_result_o;

   int checks = 0;
   int errors = 0;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .mem_allowin_i(mem_allowin_i), .excep_flush_i(excep_flush_i),
      .is_div_i(is_div_i), .div_signed_i(div_signed_i), .div_rem_i(div_rem_i),
      .src1_i(src1_i), .src2_i(src2_i), .alu_result_i(alu_result_i),
      .ex_allowin_o(ex_allowin_o), .ex_to_mem_valid_o(ex_to_mem_valid_o),
      .ex_result_o(ex_result_o), .div_busy_o(div_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic        rem;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Reference model written directly from the arithmetic rules
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn, input logic rem);
      int sa, sb;
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (!sgn) return rem ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return rem ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [31:0] ma, mb;
      ma = (sgn && a[31]) ? -a : a;
      mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) return 1;
`endif
      return 33;
   endfunction

   task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic rem, input logic mem_ok);
      @(posedge clk); #1;
      ex_valid_i = 1'b1; is_div_i = 1'b1; div_signed_i = sgn; div_rem_i = rem;
      src1_i = a; src2_i = b; mem_allowin_i = mem_ok;
   endtask

   // Waits for valid from cycle 0; returns cycle count and whether allowin leaked high early
   task automatic wait_valid(output int cyc, output logic got, output logic bad_allow);
      cyc = 0; got = 1'b0; bad_allow = 1'b0;
      while (!got && cyc <= 40) begin
         @(negedge clk);
         if (ex_to_mem_valid_o) got = 1'b1;
         else begin
            if (ex_allowin_o) bad_allow = 1'b1;
            cyc++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic rem, input logic [31:0] exp);
      int cyc; logic got, bad;
      start_div(a, b, sgn, rem, 1'b1);
      wait_valid(cyc, got, bad);
      chk({nm, "_valid_seen"}, 32'(got), 32'd1);
      chk({nm, "_latency"}, 32'(cyc), 32'(exp_latency(a, b, sgn)));
      chk({nm, "_result"}, ex_result_o, exp);
      chk({nm, "_allowin_done"}, 32'(ex_allowin_o), 32'd1);
      chk({nm, "_allowin_low_while_busy"}, 32'(bad), 32'd0);
      @(posedge clk); #1;
      ex_valid_i = 1'b0; is_div_i = 1'b0;
      @(negedge clk);
      chk({nm, "_idle_after"}, 32'(div_busy_o), 32'd0);
   endtask

   vec_t tbl[10];

   initial begin
      int cyc; logic got, bad;
      logic [31:0] a, b; logic sgn, rem;

      tbl[0] = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14};
      tbl[1] = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2};
      tbl[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD};
      tbl[3] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF};
      tbl[4] = '{32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF};
      tbl[5] = '{32'd5,          32'd0,          1'b0, 1'b1, 32'd5};
      tbl[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000};
      tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0};
      tbl[8] = '{32'd3,          32'd9,          1'b0, 1'b0, 32'd0};
      tbl[9] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF};

      rst_n = 1'b0; ex_valid_i = 1'b0; mem_allowin_i = 1'b1; excep_flush_i = 1'b0;
      is_div_i = 1'b0; div_signed_i = 1'b0; div_rem_i = 1'b0;
      src1_i = '0; src2_i = '0; alu_result_i = 32'hA5A5_0001;
      #3;
      chk("rst_allowin", 32'(ex_allowin_o), 32'd1);
      chk("rst_valid",   32'(ex_to_mem_valid_o), 32'd0);
      chk("rst_busy",    32'(div_busy_o), 32'd0);
      chk("rst_result",  ex_result_o, 32'hA5A5_0001);
      #9 rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_div($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].rem, tbl[i].exp);

      // Downstream stall: result held in DONE until mem_allowin returns
      start_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      wait_valid(cyc, got, bad);
      chk("stall_latency", 32'(cyc), 32'd33);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!ex_to_mem_valid_o || ex_result_o !== 32'd14 || !div_busy_o || ex_allowin_o) bad = 1'b1;
      end
      chk("stall_hold", 32'(bad), 32'd0);
      @(posedge clk); #1 mem_allowin_i = 1'b1;
      @(negedge clk);
      chk("stall_release_allowin", 32'(ex_allowin_o), 32'd1);
      @(posedge clk); #1 ex_valid_i = 1'b0; is_div_i = 1'b0;
      @(negedge clk);
      chk("stall_idle", 32'(div_busy_o), 32'd0);

      // Flush in BUSY cycle 10, then an ALU op passes with zero latency
      start_div(32'd1000, 32'd3, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
      excep_flush_i = 1'b1;
      @(negedge clk);
      chk("flush_valid_suppressed", 32'(ex_to_mem_valid_o), 32'd0);
      chk("flush_busy_before", 32'(div_busy_o), 32'd1);
      @(posedge clk); #1 excep_flush_i = 1'b0; ex_valid_i = 1'b0; is_div_i = 1'b0;
      @(negedge clk);
      chk("flush_idle", 32'(div_busy_o), 32'd0);
      @(posedge clk); #1;
      ex_valid_i = 1'b1; alu_result_i = 32'h1234_ABCD;
      @(negedge clk);
      chk("alu_valid", 32'(ex_to_mem_valid_o), 32'd1);
      chk("alu_result", ex_result_o, 32'h1234_ABCD);
      chk("alu_allowin", 32'(ex_allowin_o), 32'd1);
      @(posedge clk); #1 ex_valid_i = 1'b0;

      // Asynchronous reset mid-division abandons the operation
      start_div(32'd77, 32'd5, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
      #1 rst_n = 1'b0; ex_valid_i = 1'b0; is_div_i = 1'b0;
      #1 chk("midrst_busy", 32'(div_busy_o), 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_stays_idle", 32'(div_busy_o), 32'd0);

      for (int i = 0; i < 20; i++) begin
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         sgn = 1'($urandom_range(0, 1));
         rem = 1'($urandom_range(0, 1));
         run_div($sformatf("rnd%0d", i), a, b, sgn, rem, model(a, b, sgn, rem));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
